// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared capture-state encoding, mode encodings and channel slicing helper
package osc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_FULL  = 3'd4
  } cap_state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // LSB of channel ch inside a packed multi-channel sample word
  function automatic int ch_lsb(input int ch, input int dsize);
    return ch * dsize;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - single-channel sample store, one write port, registered read-before-write read port
module capture_ram #(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_waddr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  input  logic [ADDR_SIZE-1:0] i_raddr,
  output logic [DATA_SIZE-1:0] o_rdata
);

  logic [DATA_SIZE-1:0] r_mem [0:(2**ADDR_SIZE)-1];

  // Write and read in the same process so a same-address access returns the old word
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/capture_buffer.sv
// rtl/capture_buffer.sv - multi-channel pre/post trigger capture buffer with trigger-relative readout
module capture_buffer
  import osc_pkg::*;
#(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 8,
  parameter int CHANNELS  = 2,
  localparam int MEM_SIZE = 2 ** ADDR_SIZE,
  localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst,
  input  logic                          sample_valid_i,
  input  logic [CHANNELS*DATA_SIZE-1:0] sample_i,
  input  logic                          arm_i,
  input  logic                          mode_i,
  input  logic [ADDR_SIZE-1:0]          pretrig_i,
  input  logic                          trigger_i,
  input  logic                          read_done_i,
  input  logic [ADDR_SIZE-1:0]          r_addr_i,
  input  logic [CH_BITS-1:0]            r_ch_i,
  output logic [DATA_SIZE-1:0]          r_data,
  output logic                          fifo_full,
  output logic [2:0]                    state_o,
  output logic [ADDR_SIZE-1:0]          trig_idx_o
);

  cap_state_t           r_state, w_state_nx;
  logic [ADDR_SIZE-1:0] r_w_ptr, w_w_ptr_nx;
  logic [ADDR_SIZE-1:0] r_pre_cnt, w_pre_nx;
  logic [ADDR_SIZE:0]   r_post_cnt, w_post_nx;
  logic [ADDR_SIZE-1:0] r_start_addr, w_start_nx;
  logic [ADDR_SIZE-1:0] r_pretrig, w_pretrig_nx;
  logic                 r_full;
  logic                 r_rd_ok;
  logic [CH_BITS-1:0]   r_rd_ch;

  logic                 w_accept;
  logic [ADDR_SIZE:0]   w_post_target;
  logic [ADDR_SIZE:0]   w_post_inc;
  logic [ADDR_SIZE-1:0] w_raddr;
  logic [DATA_SIZE-1:0] w_ram_q [CHANNELS];
  logic [DATA_SIZE-1:0] w_rd_sel;

  assign w_accept      = sample_valid_i &&
                         (r_state == ST_PRE || r_state == ST_ARMED || r_state == ST_POST);
  assign w_post_target = (ADDR_SIZE+1)'(MEM_SIZE) - {1'b0, r_pretrig};
  assign w_post_inc    = r_post_cnt + 1'b1;
  assign w_raddr       = r_start_addr + r_addr_i;

  assign fifo_full  = r_full;
  assign state_o    = r_state;
  assign trig_idx_o = r_pretrig;
  assign r_data     = w_rd_sel;

  // One RAM per channel, all written together at the shared write pointer
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    capture_ram #(
      .DATA_SIZE(DATA_SIZE),
      .ADDR_SIZE(ADDR_SIZE)
    ) u_ram (
      .clk_i  (clk_i),
      .i_we   (w_accept),
      .i_waddr(r_w_ptr),
      .i_wdata(sample_i[ch_lsb(g, DATA_SIZE) +: DATA_SIZE]),
      .i_raddr(w_raddr),
      .o_rdata(w_ram_q[g])
    );
  end

  // State and counter register; full flag follows the state so it never pulses through reset
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_w_ptr      <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_start_addr <= '0;
      r_pretrig    <= '0;
      r_full       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_w_ptr      <= w_w_ptr_nx;
      r_pre_cnt    <= w_pre_nx;
      r_post_cnt   <= w_post_nx;
      r_start_addr <= w_start_nx;
      r_pretrig    <= w_pretrig_nx;
      r_full       <= (w_state_nx == ST_FULL);
    end
  end

  // Next-state and counter update; arm restarts from any active state and beats trigger
  always_comb begin
    w_state_nx   = r_state;
    w_w_ptr_nx   = w_accept ? (r_w_ptr + 1'b1) : r_w_ptr;
    w_pre_nx     = r_pre_cnt;
    w_post_nx    = r_post_cnt;
    w_start_nx   = r_start_addr;
    w_pretrig_nx = r_pretrig;
    unique case (r_state)
      ST_IDLE: begin
        if (arm_i) w_state_nx = ST_PRE;
      end
      ST_PRE: begin
        if (arm_i) w_state_nx = ST_PRE;
        else if (r_pre_cnt == r_pretrig) w_state_nx = ST_ARMED;
        else if (w_accept) w_pre_nx = r_pre_cnt + 1'b1;
      end
      ST_ARMED: begin
        if (arm_i) begin
          w_state_nx = ST_PRE;
        end else if (w_accept && trigger_i) begin
          w_start_nx = r_w_ptr - r_pretrig;
          w_post_nx  = (ADDR_SIZE+1)'(1);
          w_state_nx = (w_post_target == (ADDR_SIZE+1)'(1)) ? ST_FULL : ST_POST;
        end
      end
      ST_POST: begin
        if (arm_i) begin
          w_state_nx = ST_PRE;
        end else if (w_accept) begin
          w_post_nx = w_post_inc;
          if (w_post_inc == w_post_target) w_state_nx = ST_FULL;
        end
      end
      ST_FULL: begin
        if (arm_i || read_done_i) begin
          w_state_nx = (arm_i || mode_i == MODE_AUTO) ? ST_PRE : ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (w_state_nx == ST_PRE && (arm_i || r_state == ST_FULL)) begin
      w_pre_nx     = '0;
      w_post_nx    = '0;
      w_pretrig_nx = pretrig_i;
    end
  end

  // Read channel pipeline, aligned with the RAM output register
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      r_rd_ok <= 1'b0;
      r_rd_ch <= '0;
    end else begin
      r_rd_ok <= 1'b1;
      r_rd_ch <= r_ch_i;
    end
  end

  // Channel select; out-of-range channels and the post-reset cycle read as zero
  always_comb begin
    w_rd_sel = '0;
    if (r_rd_ok && int'(r_rd_ch) < CHANNELS) w_rd_sel = w_ram_q[r_rd_ch];
  end

endmodule

// File: tb/tb_capture_buffer.sv
// tb/tb_capture_buffer.sv - directed scoreboard bench for capture_buffer
module tb_capture_buffer;
  import osc_pkg::*;

  localparam int DW = 12;
  localparam int AW = 4;
  localparam int CH = 2;

  logic           clk_i = 1'b0;
  logic           rst = 1'b0;
  logic           sample_valid_i = 1'b0;
  logic [CH*DW-1:0] sample_i = '0;
  logic           arm_i = 1'b0;
  logic           mode_i = 1'b0;
  logic [AW-1:0]  pretrig_i = '0;
  logic           trigger_i = 1'b0;
  logic           read_done_i = 1'b0;
  logic [AW-1:0]  r_addr_i = '0;
  logic [0:0]     r_ch_i = '0;
  logic [DW-1:0]  r_data;
  logic           fifo_full;
  logic [2:0]     state_o;
  logic [AW-1:0]  trig_idx_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  capture_buffer #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .CHANNELS(CH)) dut (
    .clk_i(clk_i), .rst(rst), .sample_valid_i(sample_valid_i), .sample_i(sample_i),
    .arm_i(arm_i), .mode_i(mode_i), .pretrig_i(pretrig_i), .trigger_i(trigger_i),
    .read_done_i(read_done_i), .r_addr_i(r_addr_i), .r_ch_i(r_ch_i), .r_data(r_data),
    .fifo_full(fifo_full), .state_o(state_o), .trig_idx_o(trig_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input int k, input logic trig);
    sample_valid_i = 1'b1;
    sample_i       = {12'(2048 + k), 12'(k)};
    trigger_i      = trig;
    tick();
    sample_valid_i = 1'b0;
    trigger_i      = 1'b0;
  endtask

  task automatic send_run(input int first, input int last);
    for (int k = first; k <= last; k++) send(k, 1'b0);
  endtask

  task automatic pulse_arm(input int pre, input logic mode);
    pretrig_i = AW'(pre);
    mode_i    = mode;
    arm_i     = 1'b1;
    tick();
    arm_i     = 1'b0;
  endtask

  task automatic pulse_done(input logic mode);
    mode_i      = mode;
    read_done_i = 1'b1;
    tick();
    read_done_i = 1'b0;
  endtask

  task automatic rd(input int addr, input int ch, input int expv);
    r_addr_i = AW'(addr);
    r_ch_i   = 1'(ch);
    exp_q.push_back(expv);
    tick();
    chk($sformatf("rd ch%0d addr%0d", ch, addr), int'(r_data), exp_q.pop_front());
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst state", int'(state_o), 0);
    chk("rst full", int'(fifo_full), 0);
    chk("rst rdata", int'(r_data), 0);
    chk("rst trig_idx", int'(trig_idx_o), 0);
    rst = 1'b1;
    tick();

    // single-shot, pretrig 4, trigger on sample 10
    pulse_arm(4, MODE_SINGLE);
    chk("ss state pre", int'(state_o), int'(ST_PRE));
    send_run(0, 9);
    chk("ss state armed", int'(state_o), int'(ST_ARMED));
    send(10, 1'b1);
    chk("ss state post", int'(state_o), int'(ST_POST));
    send_run(11, 20);
    chk("ss full early", int'(fifo_full), 0);
    send(21, 1'b0);
    chk("ss full", int'(fifo_full), 1);
    chk("ss state full", int'(state_o), int'(ST_FULL));
    chk("ss trig_idx", int'(trig_idx_o), 4);
    rd(0, 0, 6);
    rd(4, 0, 10);
    rd(15, 0, 21);
    rd(0, 1, 12'h806);
    pulse_done(MODE_SINGLE);
    chk("ss idle", int'(state_o), int'(ST_IDLE));
    chk("ss full clr", int'(fifo_full), 0);

    // trigger gating, pretrig 8
    pulse_arm(8, MODE_SINGLE);
    send_run(0, 2);
    send(3, 1'b1);
    send(4, 1'b0);
    send(5, 1'b1);
    chk("gate pre", int'(state_o), int'(ST_PRE));
    send_run(6, 8);
    trigger_i = 1'b1;
    tick(); tick();
    trigger_i = 1'b0;
    chk("gate novalid", int'(state_o), int'(ST_ARMED));
    send(9, 1'b1);
    chk("gate post", int'(state_o), int'(ST_POST));
    send_run(10, 15);
    chk("gate full early", int'(fifo_full), 0);
    send(16, 1'b0);
    chk("gate full", int'(fifo_full), 1);
    rd(8, 0, 9);
    rd(0, 0, 1);
    rd(15, 0, 16);
    pulse_done(MODE_SINGLE);

    // zero pretrig with wrapped start address
    for (int k = 0; k < 37; k++) send(k, 1'b0);
    chk("idle no accept", int'(state_o), int'(ST_IDLE));
    pulse_arm(0, MODE_SINGLE);
    tick();
    chk("z armed", int'(state_o), int'(ST_ARMED));
    send(37, 1'b1);
    send_run(38, 51);
    chk("z full early", int'(fifo_full), 0);
    send(52, 1'b0);
    chk("z full", int'(fifo_full), 1);
    chk("z trig_idx", int'(trig_idx_o), 0);
    for (int i = 0; i < 16; i++) rd(i, 0, 37 + i);
    rd(3, 1, 2048 + 40);

    // auto re-arm, pretrig 2 latched on read_done
    pretrig_i = AW'(2);
    pulse_done(MODE_AUTO);
    chk("auto full clr", int'(fifo_full), 0);
    chk("auto state", int'(state_o), int'(ST_PRE));
    chk("auto trig_idx", int'(trig_idx_o), 2);
    send_run(100, 102);
    send(103, 1'b1);
    send_run(104, 116);
    chk("auto full", int'(fifo_full), 1);
    rd(0, 0, 101);
    rd(2, 0, 103);
    rd(15, 0, 116);
    rd(15, 1, 2048 + 116);

    // abort from POST, then arm+trigger in ARMED
    pulse_done(MODE_SINGLE);
    pulse_arm(2, MODE_SINGLE);
    send_run(0, 2);
    send(3, 1'b1);
    send_run(4, 5);
    chk("ab post", int'(state_o), int'(ST_POST));
    pulse_arm(2, MODE_SINGLE);
    chk("ab to pre", int'(state_o), int'(ST_PRE));
    send_run(10, 12);
    chk("ab armed", int'(state_o), int'(ST_ARMED));
    arm_i = 1'b1;
    send(13, 1'b1);
    arm_i = 1'b0;
    chk("ab arm beats trig", int'(state_o), int'(ST_PRE));
    send_run(20, 22);
    send(23, 1'b1);
    send_run(24, 35);
    chk("ab full early", int'(fifo_full), 0);
    send(36, 1'b0);
    chk("ab full", int'(fifo_full), 1);
    rd(0, 0, 21);
    rd(15, 0, 36);

    // arm in FULL re-arms; reset in mid-POST
    pulse_arm(2, MODE_SINGLE);
    chk("full arm pre", int'(state_o), int'(ST_PRE));
    send_run(40, 42);
    send(43, 1'b1);
    send(44, 1'b0);
    chk("rp post", int'(state_o), int'(ST_POST));
    rst = 1'b0;
    tick();
    chk("rp state", int'(state_o), 0);
    chk("rp full", int'(fifo_full), 0);
    chk("rp rdata", int'(r_data), 0);
    chk("rp trig_idx", int'(trig_idx_o), 0);
    tick();
    rst = 1'b1;
    send_run(200, 203);
    chk("rp idle", int'(state_o), int'(ST_IDLE));
    chk("rp idle full", int'(fifo_full), 0);
    pulse_arm(0, MODE_SINGLE);
    tick();
    send(50, 1'b1);
    send_run(51, 64);
    chk("rp full early", int'(fifo_full), 0);
    send(65, 1'b0);
    chk("rp cap full", int'(fifo_full), 1);
    rd(0, 0, 50);
    rd(15, 0, 65);
    rd(7, 1, 2048 + 57);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
